im_loader: RTL and testbench
============================

Name: im_loader

Overview:
- Program loader, the write side of the instruction memory. It accepts a byte stream over a valid/ready handshake, frames it into a header, 16-bit instruction words and a checksum, and drives single-word writes into the instruction memory write port.
- It holds all cores stalled until a complete program with a correct checksum is resident, then releases them.
- It sits between the host/debug byte link and the shared instruction memory used by all `NUM_C cores.

Parameters:
- MEM_DEPTH, 1025, number of 16-bit words in instruction memory (valid addresses 0..MEM_DEPTH-1).
- ADDR_W, 16, width of the instruction memory address.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- restart  in  1  synchronous pulse; from DONE or ERR, return to HDR_AL and re-assert core_hold.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept a byte; a transfer occurs when in_valid && in_ready at posedge.
- mem_we  out  1  one-cycle write strobe to instruction memory.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  16  write data.
- core_hold  out  1  1 = cores stalled, with PCs held at 0.
- done  out  1  program loaded and checksum correct.
- err  out  1  range or checksum error.

Behaviour:
- Reset (async, rst_n=0):
  - state=HDR_AL; in_ready=1; mem_we=0; mem_addr=0; mem_wdata=0.
  - core_hold=1; done=0; err=0.
  - Internal start address, count, low-byte latch and running sum all cleared.
- Frame format: all fields little-endian (low byte first).
  - START address, 16b.
  - COUNT, 16b.
  - COUNT data words, 16b each.
  - SUM, 16b: the sum of all data words mod 2^16.
- States and transitions (each advance occurs only on an accepted byte):
  - HDR_AL -> HDR_AH: START assembled.
  - HDR_AH -> HDR_CL.
  - HDR_CL -> HDR_CH: COUNT assembled.
  - HDR_CH -> range check:
    - START+COUNT > MEM_DEPTH, computed in 17 bits with no wrap -> ERR.
    - Else COUNT==0 -> SUM_L.
    - Else -> DAT_L.
  - DAT_L -> DAT_H.
  - DAT_H -> DAT_L if words remaining after this one; else -> SUM_L.
  - SUM_L -> SUM_H.
  - SUM_H -> DONE if received SUM == running sum; else -> ERR.
- in_ready=1 in all HDR/DAT/SUM states and 0 in DONE and ERR. The loader never backpressures mid-frame.
- Data writes:
  - The cycle after a DAT_H byte is accepted: mem_we=1 for exactly one cycle.
  - mem_addr = START + word index, where the index starts at 0.
  - mem_wdata = {DAT_H byte, DAT_L byte}.
  - mem_we=0 in every other cycle; mem_addr/mem_wdata hold their last values.
  - Word-to-write latency is 1 cycle, so back-to-back words can produce a write every 2 cycles.
- Running sum: cleared on entry to HDR_AL; accumulates each data word, 16-bit wrap.
- DONE:
  - done=1, core_hold=0, the cycle after the SUM_H byte is accepted.
  - Further in_valid is ignored.
- ERR:
  - err=1, core_hold=1, done=0.
  - No further mem_we.
  - Words already written are not undone.
- restart:
  - In DONE/ERR: next cycle state=HDR_AL, done=0, err=0, core_hold=1, sum cleared.
  - Ignored in all other states.
- restart coinciding with a byte accepted in DONE/ERR: impossible, since in_ready=0 there.
- rst_n asserted mid-frame: an immediate async return to reset values. A pending write strobe is dropped. The partial program remains in memory.

Test Plan:
- Load START=0, COUNT=3, words 0x0021,0x0026,0x002B, SUM=0x0072 -> three mem_we pulses at addr 0,1,2 with that data; done=1, core_hold falls the cycle after the last byte.
- START=0x0010, COUNT=1, word 0xABCD, SUM=0x1234 -> one write to 0x0010; err=1, core_hold stays 1, in_ready=0.
- START=1020, COUNT=6 -> err=1 immediately after the COUNT high byte; zero mem_we pulses.
- START=1019, COUNT=6 (ends exactly at 1024) -> accepted; six writes to 1019..1024; done=1 with a correct SUM.
- COUNT=0, SUM=0 -> no writes, done=1; then pulse restart -> done=0, core_hold=1, a new frame loads normally.
- in_valid toggled randomly during a 4-word frame, then rst_n pulsed after word 2 -> writes only for words 0,1; all outputs at reset values; a subsequent full frame loads correctly.

Source files
------------

// File: rtl/im_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface im_loader_if #(
   parameter int unsigned ADDR_W = 16
);
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;

   // Host / stream source side: drives bytes, observes the memory port.
   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );

   // Loader side: consumes bytes, drives the memory write port.
   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );
endinterface

// File: rtl/im_loader.sv
// Program loader: frames a little-endian byte stream (START, COUNT, words, SUM)
// into single-word instruction-memory writes and holds the cores until a
// complete, checksum-correct program is resident.
module im_loader #(
   parameter int unsigned MEM_DEPTH = 1025,
   parameter int unsigned ADDR_W    = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        restart,
   im_loader_if.slave  bus,
   output logic        core_hold,
   output logic        done,
   output logic        err
);

   localparam int unsigned WORD_W = 16;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned END_W  = WORD_W + 1;

   typedef enum logic [3:0] {
      HDR_AL,
      HDR_AH,
      HDR_CL,
      HDR_CH,
      DAT_L,
      DAT_H,
      SUM_L,
      SUM_H,
      DONE,
      ERR
   } state_t;

   state_t              state_q;
   state_t              state_d;

   logic [BYTE_W-1:0]   lo_q;
   logic [WORD_W-1:0]   start_q;
   logic [WORD_W-1:0]   count_q;
   logic [WORD_W-1:0]   idx_q;
   logic [WORD_W-1:0]   sum_q;

   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [WORD_W-1:0]   mem_wdata_q;
   logic                in_ready_q;
   logic                core_hold_q;
   logic                done_q;
   logic                err_q;

   logic                accept_c;
   logic [WORD_W-1:0]   word_c;
   logic [END_W-1:0]    end_c;
   logic                last_word_c;
   logic                in_ready_d;
   logic                core_hold_d;
   logic                done_d;
   logic                err_d;

   assign bus.in_ready  = in_ready_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign core_hold     = core_hold_q;
   assign done          = done_q;
   assign err           = err_q;

   // Byte acceptance, current 16-bit field and derived range / last-word terms.
   always_comb begin
      accept_c    = bus.in_valid && in_ready_q;
      word_c      = {bus.in_data, lo_q};
      end_c       = END_W'({1'b0, start_q}) + END_W'({1'b0, word_c});
      last_word_c = (idx_q + WORD_W'(1)) == count_q;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HDR_AL;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode plus next values of the registered status outputs.
   always_comb begin
      state_d     = state_q;
      in_ready_d  = 1'b1;
      core_hold_d = 1'b1;
      done_d      = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         HDR_AL: if (accept_c) state_d = HDR_AH;
         HDR_AH: if (accept_c) state_d = HDR_CL;
         HDR_CL: if (accept_c) state_d = HDR_CH;
         HDR_CH: begin
            if (accept_c) begin
               if (end_c > END_W'(MEM_DEPTH)) begin
                  state_d = ERR;
               end else if (word_c == WORD_W'(0)) begin
                  state_d = SUM_L;
               end else begin
                  state_d = DAT_L;
               end
            end
         end
         DAT_L: if (accept_c) state_d = DAT_H;
         DAT_H: begin
            if (accept_c) begin
               state_d = last_word_c ? SUM_L : DAT_L;
            end
         end
         SUM_L: if (accept_c) state_d = SUM_H;
         SUM_H: begin
            if (accept_c) begin
               state_d = (word_c == sum_q) ? DONE : ERR;
            end
         end
         DONE:    if (restart) state_d = HDR_AL;
         ERR:     if (restart) state_d = HDR_AL;
         default: state_d = HDR_AL;
      endcase

      // Status outputs follow the state being entered, so they are valid
      // the cycle after the deciding byte or restart.
      case (state_d)
         DONE: begin
            in_ready_d  = 1'b0;
            core_hold_d = 1'b0;
            done_d      = 1'b1;
         end
         ERR: begin
            in_ready_d  = 1'b0;
            err_d       = 1'b1;
         end
         default: ;
      endcase
   end

   // Field assembly, running checksum and the one-cycle memory write strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_q        <= '0;
         start_q     <= '0;
         count_q     <= '0;
         idx_q       <= '0;
         sum_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         in_ready_q  <= 1'b1;
         core_hold_q <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         mem_we_q    <= 1'b0;
         in_ready_q  <= in_ready_d;
         core_hold_q <= core_hold_d;
         done_q      <= done_d;
         err_q       <= err_d;

         if (accept_c) begin
            case (state_q)
               HDR_AL, HDR_CL, DAT_L, SUM_L: lo_q <= bus.in_data;
               HDR_AH: start_q <= word_c;
               HDR_CH: begin
                  count_q <= word_c;
                  idx_q   <= '0;
               end
               DAT_H: begin
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= ADDR_W'(start_q + idx_q);
                  mem_wdata_q <= word_c;
                  sum_q       <= sum_q + word_c;
                  idx_q       <= idx_q + WORD_W'(1);
               end
               default: ;
            endcase
         end

         // Returning to HDR_AL starts a fresh checksum and word index.
         if ((state_q == DONE || state_q == ERR) && restart) begin
            sum_q <= '0;
            idx_q <= '0;
         end
      end
   end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: frame loads, checksum/range errors, the
// memory-end boundary, empty programs, restart and mid-frame reset.
`timescale 1ns/1ps
module tb_im_loader;

   logic clk;
   logic rst_n;
   logic restart;
   logic core_hold;
   logic done;
   logic err;

   int tests_run;
   int tests_failed;

   logic [31:0] wq[$];
   logic [31:0] exp_q[$];

   im_loader_if #(.ADDR_W(16)) bus ();

   im_loader #(.MEM_DEPTH(1025), .ADDR_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .restart   (restart),
      .bus       (bus.slave),
      .core_hold (core_hold),
      .done      (done),
      .err       (err)
   );

   // 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Log every memory write strobe, sampled away from the active edge.
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) wq.push_back({bus.mem_addr, bus.mem_wdata});
   end

   task automatic send_byte(input logic [7:0] b, input bit jit);
      int n;
      if (jit) begin
         n = int'($urandom_range(0, 2));
         repeat (n) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(posedge clk); #1;
         end
      end
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w, input bit jit);
      send_byte(w[7:0], jit);
      send_byte(w[15:8], jit);
   endtask

   task automatic pulse_restart();
      bus.in_valid = 1'b0;
      restart = 1'b1;
      @(posedge clk); #1;
      restart = 1'b0;
   endtask

   task automatic check_writes(input string name);
      tests_run++;
      if (wq.size() !== exp_q.size()) begin
         $display("FAIL %s write count: got %0d expected %0d", name, wq.size(), exp_q.size());
         tests_failed++;
      end
      foreach (exp_q[i]) begin
         tests_run++;
         if (i >= wq.size()) begin
            $display("FAIL %s write %0d missing: expected %h", name, i, exp_q[i]);
            tests_failed++;
         end else if (wq[i] !== exp_q[i]) begin
            $display("FAIL %s write %0d: got %h expected %h", name, i, wq[i], exp_q[i]);
            tests_failed++;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; restart = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
      #12;
      tests_run++;
      if ({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, core_hold, done, err}
          !== {1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
         $display("FAIL reset: rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b expected 1 0 0000 0000 1 0 0",
                  bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, core_hold, done, err);
         tests_failed++;
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_load();
      wq.delete(); exp_q.delete();
      send_word(16'h0000, 0); send_word(16'h0003, 0);
      send_word(16'h0021, 0); send_word(16'h0026, 0); send_word(16'h002B, 0);
      send_byte(8'h72, 0);
      tests_run++;
      if (core_hold !== 1'b1 || done !== 1'b0) begin
         $display("FAIL basic pre-sum: hold=%b done=%b expected 1 0", core_hold, done);
         tests_failed++;
      end
      send_byte(8'h00, 0);
      tests_run++;
      if ({done, core_hold, err, bus.in_ready} !== 4'b1000) begin
         $display("FAIL basic done: done=%b hold=%b err=%b rdy=%b expected 1 0 0 0",
                  done, core_hold, err, bus.in_ready);
         tests_failed++;
      end
      exp_q.push_back({16'h0000, 16'h0021});
      exp_q.push_back({16'h0001, 16'h0026});
      exp_q.push_back({16'h0002, 16'h002B});
      check_writes("basic");
      // Bytes offered in DONE must be ignored.
      send_byte(8'h55, 0); send_byte(8'hAA, 0);
      @(posedge clk); #1;
      tests_run++;
      if (wq.size() !== 3 || done !== 1'b1) begin
         $display("FAIL basic ignore-in-done: writes=%0d done=%b expected 3 1", wq.size(), done);
         tests_failed++;
      end
      pulse_restart();
      tests_run++;
      if ({done, err, core_hold, bus.in_ready} !== 4'b0011) begin
         $display("FAIL basic restart: done=%b err=%b hold=%b rdy=%b expected 0 0 1 1",
                  done, err, core_hold, bus.in_ready);
         tests_failed++;
      end
   endtask

   task automatic test_checksum_err();
      wq.delete(); exp_q.delete();
      send_word(16'h0010, 0); send_word(16'h0001, 0);
      send_word(16'hABCD, 0); send_word(16'h1234, 0);
      @(posedge clk); #1;
      tests_run++;
      if ({err, done, core_hold, bus.in_ready} !== 4'b1010) begin
         $display("FAIL cksum err: err=%b done=%b hold=%b rdy=%b expected 1 0 1 0",
                  err, done, core_hold, bus.in_ready);
         tests_failed++;
      end
      exp_q.push_back({16'h0010, 16'hABCD});
      check_writes("cksum");
      pulse_restart();
      tests_run++;
      if ({err, core_hold, bus.in_ready} !== 3'b011) begin
         $display("FAIL cksum restart: err=%b hold=%b rdy=%b expected 0 1 1", err, core_hold, bus.in_ready);
         tests_failed++;
      end
   endtask

   task automatic test_range_err();
      wq.delete(); exp_q.delete();
      send_word(16'd1020, 0); send_word(16'd6, 0);
      tests_run++;
      if ({err, core_hold, bus.in_ready} !== 3'b110) begin
         $display("FAIL range err: err=%b hold=%b rdy=%b expected 1 1 0", err, core_hold, bus.in_ready);
         tests_failed++;
      end
      // Further bytes must not produce writes.
      send_word(16'h1111, 0); send_word(16'h2222, 0);
      @(posedge clk); #1;
      check_writes("range");
      pulse_restart();
   endtask

   task automatic test_boundary();
      wq.delete(); exp_q.delete();
      send_word(16'd1019, 0); send_word(16'd6, 0);
      tests_run++;
      if (err !== 1'b0) begin
         $display("FAIL boundary header: err=%b expected 0", err);
         tests_failed++;
      end
      for (int i = 0; i < 6; i++) begin
         send_word(16'h1000 + 16'(i), 0);
         exp_q.push_back({16'd1019 + 16'(i), 16'h1000 + 16'(i)});
      end
      send_word(16'h600F, 0);
      tests_run++;
      if ({done, err, core_hold} !== 3'b100) begin
         $display("FAIL boundary done: done=%b err=%b hold=%b expected 1 0 0", done, err, core_hold);
         tests_failed++;
      end
      check_writes("boundary");
      pulse_restart();
   endtask

   task automatic test_zero_count();
      wq.delete(); exp_q.delete();
      send_word(16'h0005, 0); send_word(16'h0000, 0); send_word(16'h0000, 0);
      tests_run++;
      if ({done, err, core_hold} !== 3'b100) begin
         $display("FAIL zero done: done=%b err=%b hold=%b expected 1 0 0", done, err, core_hold);
         tests_failed++;
      end
      check_writes("zero");
      pulse_restart();
      tests_run++;
      if ({done, core_hold, bus.in_ready} !== 3'b011) begin
         $display("FAIL zero restart: done=%b hold=%b rdy=%b expected 0 1 1", done, core_hold, bus.in_ready);
         tests_failed++;
      end
      // Fresh frame after restart; checksum wraps mod 2^16.
      wq.delete(); exp_q.delete();
      send_word(16'h0002, 0); send_word(16'h0002, 0);
      send_word(16'hFFFF, 0); send_word(16'h0003, 0); send_word(16'h0002, 0);
      tests_run++;
      if ({done, err} !== 2'b10) begin
         $display("FAIL reload done: done=%b err=%b expected 1 0", done, err);
         tests_failed++;
      end
      exp_q.push_back({16'h0002, 16'hFFFF});
      exp_q.push_back({16'h0003, 16'h0003});
      check_writes("reload");
      pulse_restart();
   endtask

   task automatic test_reset_midframe();
      wq.delete(); exp_q.delete();
      send_word(16'h0100, 1); send_word(16'h0004, 1);
      send_word(16'h1111, 1); send_word(16'h2222, 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #2;
      tests_run++;
      if ({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, core_hold, done, err}
          !== {1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
         $display("FAIL midframe reset: rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b expected 1 0 0000 0000 1 0 0",
                  bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, core_hold, done, err);
         tests_failed++;
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back({16'h0100, 16'h1111});
      exp_q.push_back({16'h0101, 16'h2222});
      check_writes("midframe");
      // A full frame after the reset must load from a clean header state.
      wq.delete(); exp_q.delete();
      send_word(16'h0200, 1); send_word(16'h0001, 1);
      send_word(16'h00AA, 1); send_word(16'h00AA, 1);
      tests_run++;
      if ({done, err, core_hold} !== 3'b100) begin
         $display("FAIL post-reset done: done=%b err=%b hold=%b expected 1 0 0", done, err, core_hold);
         tests_failed++;
      end
      exp_q.push_back({16'h0200, 16'h00AA});
      check_writes("post-reset");
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_basic_load();
      test_checksum_err();
      test_range_err();
      test_boundary();
      test_zero_count();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
